// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule engine.
// Produces one round key per clock into an 11-entry buffer, read back
// through a registered port for the round controller's AddRoundKey.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      expand key_in (accepted in IDLE only)
//   key_in     cipher key, byte 15 first (w0 = key_in[15:12])
//   rk_addr    round key index to read (0..10, 11..15 read as zero)
//   rk_out     registered read data, 1-cycle latency
//   busy       expansion in progress
//   done       one-cycle pulse after round key 10 is written
//   keys_valid all 11 round keys valid

// Single S-box byte: multiplicative inverse in GF(2^8) followed by the
// AES affine transform. Inverse is computed as a^254 (0 maps to 0).
module aes_sbox_byte (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  always_comb begin
    logic [7:0] sq;
    sq  = a;
    inv = 8'h01;
    // a^254 = a^2 * a^4 * ... * a^128
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// Four-byte column substitution: one S-box per byte lane.
module aes_sbox_col #(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0][7:0] a,
  output logic [NUM_LANES-1:0][7:0] s
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    aes_sbox_byte u_sbox (.a(a[l]), .s(s[l]));
  end
endmodule

module aes_key_expand #(
  parameter int ROUNDS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0][7:0] key_in,
  input  logic [3:0]       rk_addr,
  output logic [15:0][7:0] rk_out,
  output logic             busy,
  output logic             done,
  output logic             keys_valid
);
  localparam logic [3:0] LAST = 4'(ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

  state_t       state;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [127:0] w_reg;
  logic [127:0] key_mem [0:ROUNDS];

  logic [31:0]      w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [3:0][7:0]  rot, sub;
  logic             we;
  logic [3:0]       waddr;
  logic [127:0]     wdata;

  assign {w0, w1, w2, w3} = w_reg;

  // RotWord: {b3,b2,b1,b0} -> {b2,b1,b0,b3}
  assign rot = {w3[23:0], w3[31:24]};

  aes_sbox_col #(.NUM_LANES(4)) u_subword (.a(rot), .s(sub));

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Buffer write: key itself on the accepting edge, then one round key per edge.
  assign we    = !reset && ((state == IDLE && start) || state == EXPAND);
  assign waddr = (state == IDLE) ? 4'd0 : round;
  assign wdata = (state == IDLE) ? 128'(key_in) : {n0, n1, n2, n3};

  // Buffer carries no reset; keys_valid marks its contents.
  always_ff @(posedge clk) begin
    if (we) key_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      round      <= '0;
      rcon       <= 8'h01;
      w_reg      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      rk_out     <= '0;
    end else begin
      // Read happens before this edge's write lands: no write-through.
      rk_out <= (rk_addr <= LAST) ? key_mem[rk_addr] : '0;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w_reg      <= key_in;
            round      <= 4'd1;
            rcon       <= 8'h01;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          w_reg <= {n0, n1, n2, n3};
          round <= round + 4'd1;
          rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (round == LAST) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
            state      <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
